// File: rtl/lsu_pkg.sv
// Shared types and funct3 decode helpers for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LD  = 3'd3;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_LWU = 3'd6;

    // Access size in bytes; 0 marks an undefined code.
    function automatic logic [3:0] size_of(input logic [2:0] f3);
        logic [3:0] sz;
        case (f3)
            F3_LB, F3_LBU: sz = 4'd1;
            F3_LH, F3_LHU: sz = 4'd2;
            F3_LW, F3_LWU: sz = 4'd4;
            F3_LD:         sz = 4'd8;
            default:       sz = 4'd0;
        endcase
        return sz;
    endfunction

    function automatic logic is_signed(input logic [2:0] f3);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) || (f3 == F3_LD);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store data/strobe shifting and load extraction with
// sign or zero extension. Purely combinational.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    localparam int unsigned NB   = XLEN / 8,
    localparam int unsigned OFFW = $clog2(NB)
) (
    input  logic [OFFW-1:0] st_off_i,
    input  logic [3:0]      st_size_i,
    input  logic [XLEN-1:0] st_wdata_i,
    output logic [XLEN-1:0] st_wdata_o,
    output logic [NB-1:0]   st_wstrb_o,
    input  logic [OFFW-1:0] ld_off_i,
    input  logic [3:0]      ld_size_i,
    input  logic            ld_signed_i,
    input  logic [XLEN-1:0] ld_rdata_i,
    output logic [XLEN-1:0] ld_data_o
);

    logic [15:0]     strb_full;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] mask;
    logic            sbit;

    always_comb begin
        strb_full  = ((16'd1 << st_size_i) - 16'd1) << st_off_i;
        st_wstrb_o = strb_full[NB-1:0];
        st_wdata_o = st_wdata_i << {st_off_i, 3'b000};

        shifted = ld_rdata_i >> {ld_off_i, 3'b000};
        mask    = '0;
        sbit    = 1'b0;
        // Mask keeps the accessed bytes; sign comes from the top kept byte.
        for (int unsigned i = 0; i < NB; i++) begin
            if (i < {28'd0, ld_size_i}) begin
                mask[8*i +: 8] = '1;
            end
            if ((i + 1) == {28'd0, ld_size_i}) begin
                sbit = shifted[8*i+7];
            end
        end
        ld_data_o = (shifted & mask) | ((ld_signed_i && sbit) ? ~mask : '0);
    end

endmodule

// File: rtl/lsu.sv
// Multi-cycle load/store unit: request decode, valid/ready bus FSM, kill flag.
// Optional bus timeout enabled by defining LSU_TIMEOUT_EN.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              hlt_i,
    input  logic              flush_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              load_i,
    input  logic              store_i,
    input  logic [2:0]        funct3_i,
    input  logic [XLEN-1:0]   base_i,
    input  logic [XLEN-1:0]   offset_i,
    input  logic [XLEN-1:0]   wdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [XLEN-1:0]   result_o,
    output logic              fault_o,
    output logic              mem_valid_o,
    input  logic              mem_ready_i,
    output logic [XLEN-1:0]   mem_addr_o,
    input  logic [XLEN-1:0]   mem_rdata_i,
    output logic [XLEN-1:0]   mem_wdata_o,
    output logic [XLEN/8-1:0] mem_wstrb_o
);

    localparam int unsigned NB   = XLEN / 8;
    localparam int unsigned OFFW = $clog2(NB);

    state_e          state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [NB-1:0]   wstrb_q, wstrb_d;
    logic [OFFW-1:0] off_q, off_d;
    logic [3:0]      size_q, size_d;
    logic            sgn_q, sgn_d;
    logic            store_q, store_d;
    logic            kill_q, kill_d;
    logic            fault_q, fault_d;
    logic [XLEN-1:0] result_q, result_d;

    logic [XLEN-1:0] ea;
    logic [OFFW-1:0] req_off;
    logic [3:0]      req_size;
    logic [OFFW-1:0] size_mask;
    logic            legal;
    logic            misaligned;
    logic [XLEN-1:0] st_wdata;
    logic [NB-1:0]   st_wstrb;
    logic [XLEN-1:0] ld_data;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timed_out;
    assign timed_out = (cnt_q == CW'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT < 2);
`endif

    assign ea       = base_i + offset_i;
    assign req_off  = ea[OFFW-1:0];
    assign req_size = size_of(funct3_i);
    // Power-of-two size truncated to OFFW bits, minus one, gives the
    // alignment mask; a full-width access wraps to all ones as required.
    assign size_mask  = req_size[OFFW-1:0] - {{(OFFW-1){1'b0}}, 1'b1};
    assign misaligned = (req_off & size_mask) != '0;
    assign legal = (req_size != 4'd0)
                && ((funct3_i != F3_LD && funct3_i != F3_LWU) || (XLEN == 64))
                && (!store_i || !funct3_i[2]);

    lsu_align #(.XLEN(XLEN)) u_align (
        .st_off_i    (req_off),
        .st_size_i   (req_size),
        .st_wdata_i  (wdata_i),
        .st_wdata_o  (st_wdata),
        .st_wstrb_o  (st_wstrb),
        .ld_off_i    (off_q),
        .ld_size_i   (size_q),
        .ld_signed_i (sgn_q),
        .ld_rdata_i  (mem_rdata_i),
        .ld_data_o   (ld_data)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        off_d    = off_q;
        size_d   = size_q;
        sgn_d    = sgn_q;
        store_d  = store_q;
        kill_d   = kill_q;
        fault_d  = fault_q;
        result_d = result_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid_i && (load_i || store_i) && !flush_i) begin
                    kill_d   = 1'b0;
                    result_d = '0;
                    if (!legal || misaligned) begin
                        fault_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        fault_d = 1'b0;
                        state_d = S_BUS;
                        addr_d  = {ea[XLEN-1:OFFW], {OFFW{1'b0}}};
                        wdata_d = store_i ? st_wdata : '0;
                        wstrb_d = store_i ? st_wstrb : '0;
                        off_d   = req_off;
                        size_d  = req_size;
                        sgn_d   = is_signed(funct3_i);
                        store_d = store_i;
`ifdef LSU_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            S_BUS: begin
                if (flush_i) begin
                    kill_d = 1'b1;
                end
                if (mem_ready_i) begin
                    result_d = store_q ? '0 : ld_data;
                    state_d  = S_DONE;
                end
`ifdef LSU_TIMEOUT_EN
                else if (timed_out) begin
                    fault_d  = 1'b1;
                    result_d = '0;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_DONE: begin
                kill_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            off_q    <= '0;
            size_q   <= '0;
            sgn_q    <= 1'b0;
            store_q  <= 1'b0;
            kill_q   <= 1'b0;
            fault_q  <= 1'b0;
            result_q <= '0;
`ifdef LSU_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else if (!hlt_i) begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            off_q    <= off_d;
            size_q   <= size_d;
            sgn_q    <= sgn_d;
            store_q  <= store_d;
            kill_q   <= kill_d;
            fault_q  <= fault_d;
            result_q <= result_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign req_ready_o = (state_q == S_IDLE);
    assign busy_o      = !req_ready_o;
    assign mem_valid_o = (state_q == S_BUS);
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_wstrb_o = wstrb_q;
    assign done_o      = (state_q == S_DONE) && !kill_q && !flush_i;
    assign fault_o     = fault_q && (state_q == S_DONE);
    assign result_o    = result_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: vector table for single transactions plus
// hand-written latency, flush, reset, halt, timeout and 64-bit sequences.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hlt = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        load = 1'b0;
    logic        store = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] base = '0, offset = '0, wdata = '0, mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic        req_ready, busy, done, fault, mem_valid;
    logic [31:0] result, mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;

    logic        req_valid64 = 1'b0;
    logic [63:0] base64 = '0, offset64 = '0, wdata64 = '0, mem_rdata64 = '0;
    logic        mem_ready64 = 1'b0;
    logic        req_ready64, busy64, done64, fault64, mem_valid64;
    logic [63:0] result64, mem_addr64, mem_wdata64;
    logic [7:0]  mem_wstrb64;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu #(.XLEN(32), .TIMEOUT(4)) dut (
        .clk_i(clk), .rst_i(rst), .hlt_i(hlt), .flush_i(flush),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .load_i(load), .store_i(store), .funct3_i(funct3),
        .base_i(base), .offset_i(offset), .wdata_i(wdata),
        .busy_o(busy), .done_o(done), .result_o(result), .fault_o(fault),
        .mem_valid_o(mem_valid), .mem_ready_i(mem_ready), .mem_addr_o(mem_addr),
        .mem_rdata_i(mem_rdata), .mem_wdata_o(mem_wdata), .mem_wstrb_o(mem_wstrb)
    );

    lsu #(.XLEN(64), .TIMEOUT(4)) dut64 (
        .clk_i(clk), .rst_i(rst), .hlt_i(hlt), .flush_i(flush),
        .req_valid_i(req_valid64), .req_ready_o(req_ready64),
        .load_i(load), .store_i(store), .funct3_i(funct3),
        .base_i(base64), .offset_i(offset64), .wdata_i(wdata64),
        .busy_o(busy64), .done_o(done64), .result_o(result64), .fault_o(fault64),
        .mem_valid_o(mem_valid64), .mem_ready_i(mem_ready64), .mem_addr_o(mem_addr64),
        .mem_rdata_i(mem_rdata64), .mem_wdata_o(mem_wdata64), .mem_wstrb_o(mem_wstrb64)
    );

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] base;
        logic [31:0] off;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        flt;
        logic [31:0] addr;
        logic [31:0] mwd;
        logic [3:0]  strb;
        logic [31:0] res;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] b, input logic [31:0] o, input logic [31:0] wd);
        req_valid = 1'b1; load = ld; store = st; funct3 = f3;
        base = b; offset = o; wdata = wd;
        tick();
        req_valid = 1'b0; load = 1'b0; store = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        issue(v.ld, v.st, v.f3, v.base, v.off, v.wd);
        if (v.flt) begin
            chk($sformatf("v%0d_fault_done", idx), {63'd0, done}, 64'd1);
            chk($sformatf("v%0d_fault", idx), {63'd0, fault}, 64'd1);
            chk($sformatf("v%0d_fault_novalid", idx), {63'd0, mem_valid}, 64'd0);
            chk($sformatf("v%0d_fault_result", idx), {32'd0, result}, 64'd0);
        end else begin
            chk($sformatf("v%0d_valid", idx), {63'd0, mem_valid}, 64'd1);
            chk($sformatf("v%0d_addr", idx), {32'd0, mem_addr}, {32'd0, v.addr});
            chk($sformatf("v%0d_wdata", idx), {32'd0, mem_wdata}, {32'd0, v.mwd});
            chk($sformatf("v%0d_wstrb", idx), {60'd0, mem_wstrb}, {60'd0, v.strb});
            mem_rdata = v.rd;
            mem_ready = 1'b1;
            tick();
            mem_ready = 1'b0;
            chk($sformatf("v%0d_done", idx), {63'd0, done}, 64'd1);
            chk($sformatf("v%0d_nofault", idx), {63'd0, fault}, 64'd0);
            chk($sformatf("v%0d_result", idx), {32'd0, result}, {32'd0, v.res});
            chk($sformatf("v%0d_valid_drop", idx), {63'd0, mem_valid}, 64'd0);
        end
        tick();
        chk($sformatf("v%0d_ready", idx), {63'd0, req_ready}, 64'd1);
        chk($sformatf("v%0d_done_clr", idx), {63'd0, done}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        //              ld  st  f3    base          off           wdata         rdata         flt addr          mwdata        strb     result
        vecs[0]  = '{1, 0, 3'd0, 32'h0000_1000, 32'd3,        32'h0,        32'h80FF_FFFF, 0, 32'h0000_1000, 32'h0,        4'b0000, 32'hFFFF_FF80};
        vecs[1]  = '{1, 0, 3'd4, 32'h0000_1000, 32'd3,        32'h0,        32'h80FF_FFFF, 0, 32'h0000_1000, 32'h0,        4'b0000, 32'h0000_0080};
        vecs[2]  = '{1, 0, 3'd1, 32'h0000_2000, 32'd2,        32'h0,        32'h8001_1234, 0, 32'h0000_2000, 32'h0,        4'b0000, 32'hFFFF_8001};
        vecs[3]  = '{1, 0, 3'd5, 32'h0000_2000, 32'd2,        32'h0,        32'h8001_1234, 0, 32'h0000_2000, 32'h0,        4'b0000, 32'h0000_8001};
        vecs[4]  = '{1, 0, 3'd2, 32'h0000_0FFC, 32'd4,        32'h0,        32'hDEAD_BEEF, 0, 32'h0000_1000, 32'h0,        4'b0000, 32'hDEAD_BEEF};
        vecs[5]  = '{0, 1, 3'd1, 32'h0000_2000, 32'd2,        32'h0000_BEEF, 32'h0,        0, 32'h0000_2000, 32'hBEEF_0000, 4'b1100, 32'h0};
        vecs[6]  = '{0, 1, 3'd0, 32'h0000_0010, 32'hFFFF_FFF1, 32'h0000_00A5, 32'h0,        0, 32'h0000_0000, 32'h0000_A500, 4'b0010, 32'h0};
        vecs[7]  = '{0, 1, 3'd2, 32'h0000_3000, 32'd0,        32'h1234_5678, 32'h0,        0, 32'h0000_3000, 32'h1234_5678, 4'b1111, 32'h0};
        vecs[8]  = '{1, 0, 3'd2, 32'h0000_3000, 32'd1,        32'h0,        32'h0,        1, 32'h0,        32'h0,        4'b0000, 32'h0};
        vecs[9]  = '{1, 0, 3'd1, 32'h0000_3000, 32'd3,        32'h0,        32'h0,        1, 32'h0,        32'h0,        4'b0000, 32'h0};
        vecs[10] = '{1, 0, 3'd3, 32'h0000_3000, 32'd0,        32'h0,        32'h0,        1, 32'h0,        32'h0,        4'b0000, 32'h0};
        vecs[11] = '{1, 0, 3'd6, 32'h0000_3000, 32'd0,        32'h0,        32'h0,        1, 32'h0,        32'h0,        4'b0000, 32'h0};
        vecs[12] = '{1, 0, 3'd7, 32'h0000_3000, 32'd0,        32'h0,        32'h0,        1, 32'h0,        32'h0,        4'b0000, 32'h0};
        vecs[13] = '{0, 1, 3'd4, 32'h0000_3000, 32'd0,        32'h0,        32'h0,        1, 32'h0,        32'h0,        4'b0000, 32'h0};
        vecs[14] = '{1, 0, 3'd0, 32'h0000_4000, 32'd0,        32'h0,        32'h0000_007F, 0, 32'h0000_4000, 32'h0,        4'b0000, 32'h0000_007F};

        // Reset state
        tick(); tick();
        chk("rst_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_valid", {63'd0, mem_valid}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_fault", {63'd0, fault}, 64'd0);
        chk("rst_result", {32'd0, result}, 64'd0);
        chk("rst_addr", {32'd0, mem_addr}, 64'd0);
        chk("rst_wstrb", {60'd0, mem_wstrb}, 64'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 15; i++) begin
            run_vec(vecs[i], i);
        end

        // Latency: mem_ready one cycle late, done exactly 3 cycles after accept
        issue(1'b1, 1'b0, 3'd0, 32'h0000_1000, 32'd3, 32'h0);
        chk("lat_c1_valid", {63'd0, mem_valid}, 64'd1);
        chk("lat_c1_done", {63'd0, done}, 64'd0);
        chk("lat_c1_busy", {63'd0, busy}, 64'd1);
        tick();
        chk("lat_c2_valid", {63'd0, mem_valid}, 64'd1);
        chk("lat_c2_done", {63'd0, done}, 64'd0);
        mem_rdata = 32'h80FF_FFFF;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("lat_c3_done", {63'd0, done}, 64'd1);
        chk("lat_c3_result", {32'd0, result}, 64'hFFFF_FF80);
        tick();

        // Flush during BUS on a store: strobes still presented, done suppressed
        issue(1'b0, 1'b1, 3'd2, 32'h0000_5000, 32'd0, 32'hCAFE_F00D);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flbus_valid", {63'd0, mem_valid}, 64'd1);
        chk("flbus_wstrb", {60'd0, mem_wstrb}, 64'hF);
        chk("flbus_wdata", {32'd0, mem_wdata}, 64'hCAFE_F00D);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("flbus_nodone", {63'd0, done}, 64'd0);
        chk("flbus_busy", {63'd0, busy}, 64'd1);
        tick();
        chk("flbus_ready", {63'd0, req_ready}, 64'd1);

        // Flush in DONE suppresses the pulse combinationally
        issue(1'b1, 1'b0, 3'd2, 32'h0000_6000, 32'd0, 32'h0);
        mem_rdata = 32'h1111_2222;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        flush = 1'b1;
        #1;
        chk("fldone_nodone", {63'd0, done}, 64'd0);
        tick();
        flush = 1'b0;
        chk("fldone_ready", {63'd0, req_ready}, 64'd1);

        // Reset in BUS abandons the transaction
        issue(1'b0, 1'b1, 3'd0, 32'h0000_7000, 32'd1, 32'h0000_0055);
        chk("rstbus_valid_pre", {63'd0, mem_valid}, 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstbus_valid", {63'd0, mem_valid}, 64'd0);
        chk("rstbus_ready", {63'd0, req_ready}, 64'd1);
        chk("rstbus_wstrb", {60'd0, mem_wstrb}, 64'd0);
        chk("rstbus_addr", {32'd0, mem_addr}, 64'd0);
        chk("rstbus_wdata", {32'd0, mem_wdata}, 64'd0);
        run_vec(vecs[4], 100);

        // hlt for 3 cycles in BUS: outputs frozen, mem_ready ignored
        issue(1'b0, 1'b1, 3'd0, 32'h0000_8000, 32'd2, 32'h0000_0077);
        hlt = 1'b1;
        mem_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("hlt%0d_valid", c), {63'd0, mem_valid}, 64'd1);
            chk($sformatf("hlt%0d_addr", c), {32'd0, mem_addr}, 64'h8000);
            chk($sformatf("hlt%0d_wstrb", c), {60'd0, mem_wstrb}, 64'b0100);
            chk($sformatf("hlt%0d_wdata", c), {32'd0, mem_wdata}, 64'h0077_0000);
            chk($sformatf("hlt%0d_done", c), {63'd0, done}, 64'd0);
        end
        hlt = 1'b0;
        tick();
        mem_ready = 1'b0;
        chk("hlt_done", {63'd0, done}, 64'd1);
        chk("hlt_result", {32'd0, result}, 64'd0);
        tick();

`ifdef LSU_TIMEOUT_EN
        // Timeout: mem_ready never arrives
        issue(1'b1, 1'b0, 3'd2, 32'h0000_9000, 32'd0, 32'h0);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("to%0d_valid", c), {63'd0, mem_valid}, 64'd1);
            chk($sformatf("to%0d_done", c), {63'd0, done}, 64'd0);
            tick();
        end
        chk("to_valid_drop", {63'd0, mem_valid}, 64'd0);
        chk("to_done", {63'd0, done}, 64'd1);
        chk("to_fault", {63'd0, fault}, 64'd1);
        tick();
        chk("to_ready", {63'd0, req_ready}, 64'd1);
`endif

        // 64-bit instance: SD at ea 0x8, then LW/LWU from the upper word
        req_valid64 = 1'b1; store = 1'b1; funct3 = 3'd3;
        base64 = 64'h0; offset64 = 64'h8; wdata64 = 64'h0123_4567_89AB_CDEF;
        tick();
        req_valid64 = 1'b0; store = 1'b0;
        chk("sd64_addr", mem_addr64, 64'h8);
        chk("sd64_wstrb", {56'd0, mem_wstrb64}, 64'hFF);
        chk("sd64_wdata", mem_wdata64, 64'h0123_4567_89AB_CDEF);
        mem_ready64 = 1'b1;
        tick();
        mem_ready64 = 1'b0;
        chk("sd64_done", {63'd0, done64}, 64'd1);
        tick();
        for (int k = 0; k < 2; k++) begin
            logic [63:0] exp64;
            exp64 = (k == 0) ? 64'hFFFF_FFFF_8000_0000 : 64'h0000_0000_8000_0000;
            req_valid64 = 1'b1; load = 1'b1; funct3 = (k == 0) ? 3'd2 : 3'd6;
            base64 = 64'h100; offset64 = 64'h4;
            tick();
            req_valid64 = 1'b0; load = 1'b0;
            chk($sformatf("lw64_%0d_addr", k), mem_addr64, 64'h100);
            chk($sformatf("lw64_%0d_wstrb", k), {56'd0, mem_wstrb64}, 64'h0);
            mem_rdata64 = 64'h8000_0000_0000_0000;
            mem_ready64 = 1'b1;
            tick();
            mem_ready64 = 1'b0;
            chk($sformatf("lw64_%0d_done", k), {63'd0, done64}, 64'd1);
            chk($sformatf("lw64_%0d_result", k), result64, exp64);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
